// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP multiplier operand stage: class-bit indices,
// canonical quiet-NaN pattern and the stage state encoding.
package fp_mul_pkg;

  localparam int CLS_NAN    = 3;
  localparam int CLS_INF    = 2;
  localparam int CLS_ZERO   = 1;
  localparam int CLS_DENORM = 0;

  // Bit 0 is "main entry valid", bit 1 is "skid entry valid".
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b01,
    ST_FULL2 = 2'b11
  } stage_state_e;

  // Sign 0, exponent all-ones, fraction MSB set; caller truncates to its width.
  function automatic logic [63:0] canon_qnan(input int mant_w, input int exp_w);
    logic [63:0] v;
    v = (((64'd1 << exp_w) - 64'd1) << mant_w) | (64'd1 << (mant_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one IEEE-754 operand; denormals are flushed to
// a zero of the same sign and flagged as both zero and denorm.
module fp_classify
  import fp_mul_pkg::*;
#(
  parameter int MANT = 23,
  parameter int EXP  = 8,
  localparam int W   = MANT + EXP + 1
) (
  input  logic [W-1:0] operand,
  output logic [W-1:0] flushed,
  output logic [3:0]   cls
);

  logic exp_ones;
  logic exp_zero;
  logic frac_zero;

  assign exp_ones  = &operand[W-2:MANT];
  assign exp_zero  = ~|operand[W-2:MANT];
  assign frac_zero = ~|operand[MANT-1:0];

  always_comb begin
    cls             = '0;
    cls[CLS_NAN]    = exp_ones & ~frac_zero;
    cls[CLS_INF]    = exp_ones & frac_zero;
    cls[CLS_ZERO]   = exp_zero;
    cls[CLS_DENORM] = exp_zero & ~frac_zero;
    flushed         = operand;
    if (cls[CLS_DENORM]) flushed = {operand[W-1], {(W-1){1'b0}}};
  end

endmodule

// File: rtl/fp_mul_operand_stage.sv
// Operand intake stage ahead of the FP multiplier: 2-entry skid buffer,
// per-operand classify/flush and special-product resolution.
// Optional macro FP_MUL_OPERAND_STATS_EN adds saturating transfer counters.
module fp_mul_operand_stage
  import fp_mul_pkg::*;
#(
  parameter int MANT = 23,
  parameter int EXP  = 8,
  localparam int W   = MANT + EXP + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [3:0]   out_cls_a,
  output logic [3:0]   out_cls_b,
  output logic         out_special,
  output logic [W-1:0] out_special_val
`ifdef FP_MUL_OPERAND_STATS_EN
  ,
  input  logic         stat_clr,
  output logic [15:0]  stat_pairs,
  output logic [15:0]  stat_special
`endif
);

  localparam int PW = 3 * W + 9;
  localparam logic [W-1:0] QNAN = W'(canon_qnan(MANT, EXP));

  // Handshake: a pair moves on a rising edge where valid and ready are both
  // high; out_* hold while out_valid && !out_ready; in_ready == skid empty.
  logic [W-1:0] flush_a, flush_b, special_val;
  logic [3:0]   cls_a, cls_b;
  logic         special, sign_p, any_nan, any_inf, any_zero;
  logic [PW-1:0] in_pay, main_pay, skid_pay;
  stage_state_e state, state_next;
  logic accept, drain, load_main, main_from_skid, load_skid;

  fp_classify #(.MANT(MANT), .EXP(EXP)) u_cls_a (
    .operand (in_a),
    .flushed (flush_a),
    .cls     (cls_a)
  );

  fp_classify #(.MANT(MANT), .EXP(EXP)) u_cls_b (
    .operand (in_b),
    .flushed (flush_b),
    .cls     (cls_b)
  );

  assign any_nan  = cls_a[CLS_NAN] | cls_b[CLS_NAN];
  assign any_inf  = cls_a[CLS_INF] | cls_b[CLS_INF];
  assign any_zero = cls_a[CLS_ZERO] | cls_b[CLS_ZERO];
  assign sign_p   = in_a[W-1] ^ in_b[W-1];

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (any_nan || (any_inf && any_zero)) begin
      special     = 1'b1;
      special_val = QNAN;
    end else if (any_inf) begin
      special     = 1'b1;
      special_val = {sign_p, {EXP{1'b1}}, {MANT{1'b0}}};
    end else if (any_zero) begin
      special     = 1'b1;
      special_val = {sign_p, {(W-1){1'b0}}};
    end
  end

  assign in_pay = {flush_a, flush_b, cls_a, cls_b, special, special_val};
  assign {out_a, out_b, out_cls_a, out_cls_b, out_special, out_special_val} = main_pay;

  assign out_valid = state[0];
  assign in_ready  = ~state[1];
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_FULL1;
          load_main  = 1'b1;
        end
      end
      ST_FULL1: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_next = ST_FULL2;
          load_skid  = 1'b1;
        end else if (drain) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        if (drain) begin
          state_next     = ST_FULL1;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pay <= '0;
      skid_pay <= '0;
    end else begin
      if (load_main) main_pay <= main_from_skid ? skid_pay : in_pay;
      if (load_skid) skid_pay <= in_pay;
    end
  end

`ifdef FP_MUL_OPERAND_STATS_EN
  // A clear wins over a coincident transfer; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pairs   <= '0;
      stat_special <= '0;
    end else if (stat_clr) begin
      stat_pairs   <= '0;
      stat_special <= '0;
    end else if (drain) begin
      if (stat_pairs != 16'hFFFF) stat_pairs <= stat_pairs + 16'd1;
      if (out_special && stat_special != 16'hFFFF) stat_special <= stat_special + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fp_mul_operand_stage.md
Name: fp_mul_operand_stage

Overview:
- Registered operand-intake stage that sits directly upstream of the combinational IEEE-754 multiplier shell.
- Accepts (a, b) operand pairs over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Classifies each operand and flushes denormals to zero. Resolves special-case products (NaN, Inf, zero) so the multiplier's result can be bypassed.
- Presents registered, handshaked operands and flags to the multiplier and result logic.

Parameters:
- MANT, 23, mantissa width (fraction bits).
- EXP, 8, exponent width.
- W is derived as MANT+EXP+1, the full word width (32 by default; 16 for MANT=10, EXP=5).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  stage can accept a pair.
- in_a  in  W  operand a, IEEE-754.
- in_b  in  W  operand b, IEEE-754.
- out_valid  out  1  registered pair valid toward the multiplier.
- out_ready  in  1  downstream accepts.
- out_a  out  W  operand a after denormal flush.
- out_b  out  W  operand b after denormal flush.
- out_cls_a  out  4  class of a: {nan, inf, zero, denorm}.
- out_cls_b  out  4  class of b: {nan, inf, zero, denorm}.
- out_special  out  1  product is predetermined; downstream selects out_special_val.
- out_special_val  out  W  predetermined product.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, in_ready=1.
  - All data and flag registers are 0.
  - Skid entry is empty.
  - Reset mid-transfer drops both buffered pairs; there is no partial output.
- Handshake:
  - A transfer occurs when valid&ready are both high on a rising edge.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - in_ready is a register output equal to "skid empty"; there is no combinational in→out path.
- Latency: 1 cycle from input acceptance to out_valid when the stage is empty. Throughput is 1 pair/cycle when out_ready=1.
- States (derived from main_v and skid_v):
  - EMPTY (0,0): accept → FULL1.
  - FULL1 (1,0):
    - accept and out_ready → FULL1, main reloads.
    - accept and !out_ready → FULL2, pair goes to skid.
    - !accept and out_ready → EMPTY.
  - FULL2 (1,1): in_ready=0. On out_ready, skid moves to main → FULL1.
  - A simultaneous accept and drain in FULL1 loads main with the new pair and leaves skid empty.
- Classification (computed on input, stored with the pair):
  - exp==all-ones and frac!=0 → nan.
  - exp==all-ones and frac==0 → inf.
  - exp==0 and frac==0 → zero.
  - exp==0 and frac!=0 → denorm. The operand is flushed to signed zero, so both the zero and denorm bits are set.
- Special resolution (priority order); s = sign_a ^ sign_b:
  1. Any nan, or inf×zero (zero includes flushed denorms) → special=1, val = canonical qNaN: sign 0, exp all-ones, frac MSB=1 (0x7FC00000 for 32-bit).
  2. Any inf → special=1, val = {s, all-ones, 0}.
  3. Any zero → special=1, val = {s, 0, 0}.
  4. Otherwise special=0, val=0.
- out_a and out_b always carry the flushed operands, including for special pairs.

Optional Feature:
- Macro: FP_MUL_OPERAND_STATS_EN.
- With the macro defined:
  - Adds output port stat_pairs (16 bits): counts pairs transferred on the output side.
  - Adds output port stat_special (16 bits): counts those transfers with out_special=1.
  - Both counters saturate at 0xFFFF and reset to 0 asynchronously.
  - Adds input port stat_clr (1 bit): synchronous clear. If stat_clr coincides with a transfer, the counter is cleared and that transfer is not counted.
- Without the macro: the three ports and both counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fp_mul_pkg holds:
  - class-bit index constants (CLS_NAN=3, CLS_INF=2, CLS_ZERO=1, CLS_DENORM=0);
  - a parameterised canonical qNaN constant function;
  - the stage state encoding.
- One sub-module: fp_classify, a combinational classifier plus flush for a single operand, instantiated twice. Special resolution and the skid buffer live in the top module.

Test Plan:
- Basic pair: a=0xC0E00000 (-7), b=0x40A00000 (5), out_ready=1 → out_valid next cycle; out_a/out_b unchanged; cls=0/0; special=0.
- Backpressure: issue 3 pairs back-to-back with out_ready=0 → first in main, second in skid; in_ready=0 after the 2nd accept; 3rd pair held upstream. Release out_ready → pairs emerge in order with none lost or duplicated.
- Zero×Inf: a=0x00000000, b=0xFF800000 → special=1, val=0x7FC00000, cls_a=0010, cls_b=0100.
- Inf×finite: a=0x7F800000, b=0xC0E00000 → special=1, val=0xFF800000. Signed zero case: a=0xC0E00000, b=0x00000000 → val=0x80000000.
- Denormal flush: a=0x80000001, b=0x3F800000 → out_a=0x80000000, cls_a=0011, special=1, val=0x80000000. Repeat with MANT=10, EXP=5: a=0x0001 → out_a=0x0000, val=0x0000.
- Async reset while in FULL2 → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge. After release, 0x5300×0x4D00 (16-bit build) passes through cleanly. With the stats macro defined, both counters read 0.
